// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory write side.
package instr_mem_pkg;

    localparam logic [31:0] IMEM_BASE     = 32'hBFC00000;
    localparam int          IMEM_A_LENGTH = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_write_reg.sv
// Registered byte write port: one-cycle latency, address/data hold while idle.
module byte_write_reg #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          we_o,
    output logic [AW-1:0] wa_o,
    output logic [DW-1:0] wd_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            we_o <= 1'b0;
            wa_o <= '0;
            wd_o <= '0;
        end else begin
            we_o <= wr_en_i;
            if (wr_en_i) begin
                wa_o <= wr_addr_i;
                wd_o <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-serial program loader feeding the instruction memory write port.
// Optional trailer checksum byte and csum_err output when LOADER_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting data bytes, each written one cycle later
// CHECK  | accepting the single checksum trailer (checksum build only)
// FINISH | one-cycle done pulse, then back to IDLE
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int A_length = IMEM_A_LENGTH,
    parameter int D_length = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [A_length-1:0] base_addr,
    input  logic [A_length:0]   len,
    input  logic                in_valid,
    input  logic [D_length-1:0] in_data,
    output logic                in_ready,
    output logic                WE,
    output logic [A_length-1:0] WA,
    output logic [D_length-1:0] WD,
    output logic                busy,
`ifdef LOADER_CHECKSUM_EN
    output logic                csum_err,
`endif
    output logic                done
);

    localparam logic [A_length:0]   LEN_MAX  = {1'b1, {A_length{1'b0}}};
    localparam logic [A_length:0]   REM_ONE  = {{A_length{1'b0}}, 1'b1};
    localparam logic [A_length-1:0] ADDR_ONE = {{(A_length-1){1'b0}}, 1'b1};

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CHECK;
`else
    localparam loader_state_t AFTER_DATA = FINISH;
`endif

    loader_state_t       state_q, state_d;
    logic [A_length-1:0] addr_q, addr_d;
    logic [A_length:0]   rem_q, rem_d;
    logic [A_length:0]   len_sat;
    logic                wr_en;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       err_q, err_d;
    assign csum_err = err_q;
`endif

    assign len_sat = (len > LEN_MAX) ? LEN_MAX : len;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        wr_en    = 1'b0;
        in_ready = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = len_sat;
                    state_d = (len_sat == '0) ? AFTER_DATA : LOAD;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en  = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                    rem_d  = rem_q - REM_ONE;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + 8'(in_data);
`endif
                    if (rem_q == REM_ONE) state_d = AFTER_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // trailer is folded into the sum but never written
                    err_d   = ((sum_q + 8'(in_data)) != 8'd0);
                    state_d = FINISH;
                end
            end
`endif
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    byte_write_reg #(
        .AW(A_length),
        .DW(D_length)
    ) u_wr (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en),
        .wr_addr_i(addr_q),
        .wr_data_i(in_data),
        .we_o     (WE),
        .wa_o     (WA),
        .wd_o     (WD)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed and randomized loads against a byte-memory model.
module tb_instr_mem_loader;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [11:0] base_addr;
    logic [12:0] len;
    logic [7:0]  in_data;
    logic        in_ready, WE, busy, done;
    logic [11:0] WA;
    logic [7:0]  WD;
`ifdef LOADER_CHECKSUM_EN
    logic        csum_err;
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    instr_mem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .WE       (WE),
        .WA       (WA),
        .WD       (WD),
        .busy     (busy),
`ifdef LOADER_CHECKSUM_EN
        .csum_err (csum_err),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mem_dut [DEPTH];
    logic [7:0] mem_ref [DEPTH];
    int         wcnt    [DEPTH];
    logic [7:0] fixed_q [$];
    logic       vpat_q  [$];
    logic [7:0] trailer_b = 8'h00;
    int         ign_start_at = -1;

    // memory as seen by the instruction RAM: capture every issued write
    always @(negedge clk) begin
        if (WE === 1'b1) begin
            mem_dut[WA] = WD;
            wcnt[WA]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One load; model tracks address, remaining count and running sum.
    task automatic run_load(input logic [11:0] b, input int l, input int gap_pct, input int abort_after);
        int         rem;
        int         rem0;
        int         addr;
        int         acc;
        int         cyc;
        logic [7:0] sum;
        logic       v;
        logic [7:0] d;
        rem  = (l > DEPTH) ? DEPTH : l;
        rem0 = rem;
        addr = b;
        acc  = 0;
        cyc  = 0;
        sum  = 8'd0;
        start = 1'b1; base_addr = b; len = 13'(l);
        @(posedge clk); #1;
        start = 1'b0; base_addr = 12'($urandom); len = 13'($urandom);
        while (rem > 0 && cyc < 20000) begin
            v = ($urandom_range(0, 99) >= gap_pct);
            if (vpat_q.size() > 0) v = vpat_q.pop_front();
            d = 8'($urandom);
            if (v && fixed_q.size() > 0) d = fixed_q.pop_front();
            in_valid = v;
            in_data  = d;
            if (cyc == ign_start_at) begin
                start = 1'b1; base_addr = 12'hABC; len = 13'd7;
            end
            chk("in_ready_load", in_ready, 1);
            chk("busy_load", busy, 1);
            chk("done_load", done, 0);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            chk("we_follows_accept", WE, v);
            if (v) begin
                chk("wa", WA, addr);
                chk("wd", WD, d);
                mem_ref[addr] = d;
                sum  = sum + d;
                addr = (addr + 1) % DEPTH;
                rem--;
                acc++;
                if (rem == 0 && TRL == 0) chk("done_on_last_we", done, 1);
                if (acc == abort_after) break;
            end
            in_valid = 1'b0;
        end
        in_valid = 1'b0;
        if (abort_after >= 0 && acc == abort_after) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("rst_we", WE, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_done", done, 0);
            return;
        end
        chk("load_remaining", rem, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("check_in_ready", in_ready, 1);
        chk("check_done", done, 0);
        chk("check_busy", busy, 1);
        in_valid = 1'b1;
        in_data  = trailer_b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("trailer_not_written", WE, 0);
        chk("csum_err_finish", csum_err, ((sum + trailer_b) & 8'hFF) != 0);
`else
        chk("we_finish", WE, rem0 > 0);
`endif
        chk("done_finish", done, 1);
        chk("busy_finish", busy, 1);
        @(posedge clk); #1;
        chk("done_idle", done, 0);
        chk("busy_idle", busy, 0);
        chk("in_ready_idle", in_ready, 0);
        chk("we_idle", WE, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("csum_err_held", csum_err, ((sum + trailer_b) & 8'hFF) != 0);
`endif
    endtask

    initial begin
        int bad;
        logic [31:0] word;
        for (int i = 0; i < DEPTH; i++) begin
            mem_dut[i] = 8'h00; mem_ref[i] = 8'h00; wcnt[i] = 0;
        end
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        base_addr = 12'h000; len = 13'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_we", WE, 0);
        chk("reset_wa", WA, 0);
        chk("reset_wd", WD, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_in_ready", in_ready, 0);
        rst = 1'b0;

        // word load, MSB first
        fixed_q = '{8'h00, 8'h50, 8'h05, 8'h13};
        trailer_b = 8'h00;
        run_load(12'h000, 4, 0, -1);
        word = {mem_dut[0], mem_dut[1], mem_dut[2], mem_dut[3]};
        chk("word_at_0", word, 32'h00500513);

        // valid pattern with gaps
        vpat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_load(12'h010, 3, 0, -1);

        // wrap, then zero length
        run_load(12'hFFE, 4, 0, -1);
        run_load(12'h555, 0, 0, -1);

        // reset after three accepted bytes, then fresh load at 0x100
        run_load(12'h020, 8, 0, 3);
        run_load(12'h100, 5, 20, -1);

        // start pulse mid-load must not disturb the transfer
        ign_start_at = 2;
        run_load(12'h040, 6, 20, -1);
        ign_start_at = -1;

        // full-depth loads: exact and saturated length, both wrapping
        for (int i = 0; i < DEPTH; i++) wcnt[i] = 0;
        run_load(12'h123, 4096, 0, -1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (wcnt[i] != 1) bad++;
        chk("full_once_4096", bad, 0);
        for (int i = 0; i < DEPTH; i++) wcnt[i] = 0;
        run_load(12'h007, 5000, 0, -1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (wcnt[i] != 1) bad++;
        chk("full_once_saturated", bad, 0);

`ifdef LOADER_CHECKSUM_EN
        fixed_q = '{8'h01, 8'h02};
        trailer_b = 8'hFD;
        run_load(12'h200, 2, 0, -1);
        chk("csum_ok_directed", csum_err, 0);
        fixed_q = '{8'h01, 8'h02};
        trailer_b = 8'hFC;
        run_load(12'h200, 2, 0, -1);
        chk("csum_bad_directed", csum_err, 1);
`endif

        for (int k = 0; k < 8; k++) begin
            trailer_b = 8'($urandom);
            run_load(12'($urandom), $urandom_range(0, 40), 30, -1);
        end

        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_dut[i] !== mem_ref[i]) bad++;
        chk("memory_image", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
